vga_bitplane_writer: RTL and testbench

//  Fills the 64x64 three-bitplane image memory (64 rows x 64 bit per colour) that the VGA display path reads.

---
 rtl/vga_bitplane_writer.sv | 180 ++++++++++++++++++
 tb/tb_vga_bitplane_writer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_bitplane_writer.sv
`default_nettype none
// ============================================================================
// Module      : vga_bitplane_writer
// Description : Converts a raster RGB565 pixel stream (valid/ready) into three
//               1-bit-per-pixel bitplanes by per-channel thresholding. Pixels
//               are packed MSB-first, 64 per row, and one row write is emitted
//               to the red/green/blue image RAMs per completed row.
//               Optional feature macro: VGA_BITPLANE_DITHER_EN (2x2 ordered
//               dither on the thresholds).
// Revision    : 1.0 - initial release
// ============================================================================
module vga_bitplane_writer #(
   parameter int R_THR = 16,
   parameter int G_THR = 32,
   parameter int B_THR = 16
) (
   input  logic        vga_clk,
   input  logic        rst,
   input  logic        frame_start,
   input  logic        pix_valid,
   input  logic [15:0] pix_data,
   output logic        pix_ready,
   output logic        busy,
   output logic        frame_done,
   output logic        ram_we,
   output logic [5:0]  ram_addr,
   output logic [63:0] red_ram_data,
   output logic [63:0] green_ram_data,
   output logic [63:0] blue_ram_data
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [4:0] C_R_THR = 5'(R_THR);
   localparam logic [5:0] C_G_THR = 6'(G_THR);
   localparam logic [4:0] C_B_THR = 5'(B_THR);

   logic [1:0]  r_state;
   logic [5:0]  r_x;
   logic [5:0]  r_y;
   logic [63:0] r_red_sr;
   logic [63:0] r_grn_sr;
   logic [63:0] r_blu_sr;
   logic [5:0]  r_ram_addr;
   logic [63:0] r_red_data;
   logic [63:0] r_grn_data;
   logic [63:0] r_blu_data;

   logic [4:0]  w_r_thr;
   logic [5:0]  w_g_thr;
   logic [4:0]  w_b_thr;
   logic        w_r_bit;
   logic        w_g_bit;
   logic        w_b_bit;
   logic        w_xfer;
   logic        w_row_end;

`ifdef VGA_BITPLANE_DITHER_EN
   logic signed [7:0] w_off;
   logic signed [7:0] w_r_sum;
   logic signed [7:0] w_g_sum;
   logic signed [7:0] w_b_sum;

   // Position-dependent threshold: base plus 2x2 Bayer offset, clamped to channel range
   always_comb begin
      w_off = 8'sd0;
      case ({r_y[0], r_x[0]})
         2'b00:   w_off = -8'sd6;
         2'b01:   w_off =  8'sd2;
         2'b10:   w_off =  8'sd6;
         default: w_off = -8'sd2;
      endcase
      w_r_sum = $signed({3'b000, C_R_THR}) + w_off;
      w_g_sum = $signed({2'b00, C_G_THR}) + (w_off <<< 1);
      w_b_sum = $signed({3'b000, C_B_THR}) + w_off;

      if (w_r_sum < 8'sd0)       w_r_thr = 5'd0;
      else if (w_r_sum > 8'sd31) w_r_thr = 5'd31;
      else                       w_r_thr = w_r_sum[4:0];

      if (w_g_sum < 8'sd0)       w_g_thr = 6'd0;
      else if (w_g_sum > 8'sd63) w_g_thr = 6'd63;
      else                       w_g_thr = w_g_sum[5:0];

      if (w_b_sum < 8'sd0)       w_b_thr = 5'd0;
      else if (w_b_sum > 8'sd31) w_b_thr = 5'd31;
      else                       w_b_thr = w_b_sum[4:0];
   end
`else
   assign w_r_thr = C_R_THR;
   assign w_g_thr = C_G_THR;
   assign w_b_thr = C_B_THR;
`endif

   assign w_r_bit   = (pix_data[15:11] >= w_r_thr);
   assign w_g_bit   = (pix_data[10:5]  >= w_g_thr);
   assign w_b_bit   = (pix_data[4:0]   >= w_b_thr);

   assign pix_ready = (r_state == S_FILL);
   assign busy      = (r_state == S_FILL) || (r_state == S_WRITE);
   assign ram_we    = (r_state == S_WRITE);
   assign frame_done = (r_state == S_DONE);

   // A transfer only counts when no frame restart preempts it
   assign w_xfer    = pix_ready && pix_valid && !frame_start;
   assign w_row_end = w_xfer && (r_x == 6'd63);

   assign ram_addr       = r_ram_addr;
   assign red_ram_data   = r_red_data;
   assign green_ram_data = r_grn_data;
   assign blue_ram_data  = r_blu_data;

   // Control FSM, pixel/row counters and per-channel shift registers
   always_ff @(posedge vga_clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_x      <= 6'd0;
         r_y      <= 6'd0;
         r_red_sr <= 64'd0;
         r_grn_sr <= 64'd0;
         r_blu_sr <= 64'd0;
      end else if (frame_start) begin
         r_state  <= S_FILL;
         r_x      <= 6'd0;
         r_y      <= 6'd0;
         r_red_sr <= 64'd0;
         r_grn_sr <= 64'd0;
         r_blu_sr <= 64'd0;
      end else begin
         case (r_state)
            S_FILL: begin
               if (w_xfer) begin
                  r_red_sr <= {r_red_sr[62:0], w_r_bit};
                  r_grn_sr <= {r_grn_sr[62:0], w_g_bit};
                  r_blu_sr <= {r_blu_sr[62:0], w_b_bit};
                  r_x      <= r_x + 6'd1;
                  if (r_x == 6'd63) begin
                     r_state <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               if (r_y == 6'd63) begin
                  r_state <= S_DONE;
               end else begin
                  r_y     <= r_y + 6'd1;
                  r_x     <= 6'd0;
                  r_state <= S_FILL;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Row output registers: captured on the last pixel so they are valid during WRITE, held otherwise
   always_ff @(posedge vga_clk) begin
      if (rst) begin
         r_ram_addr <= 6'd0;
         r_red_data <= 64'd0;
         r_grn_data <= 64'd0;
         r_blu_data <= 64'd0;
      end else if (w_row_end) begin
         r_ram_addr <= r_y;
         r_red_data <= {r_red_sr[62:0], w_r_bit};
         r_grn_data <= {r_grn_sr[62:0], w_g_bit};
         r_blu_data <= {r_blu_sr[62:0], w_b_bit};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_bitplane_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_bitplane_writer
// Description : Self-checking bench for vga_bitplane_writer. Stimulus pushes
//               expected row writes into a queue; a negedge monitor pops and
//               compares on each ram_we and checks frame_done timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_bitplane_writer;

   localparam int          C_TIMEOUT = 200;
   localparam logic [63:0] C_ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef struct packed {
      logic [5:0]  addr;
      logic [63:0] r;
      logic [63:0] g;
      logic [63:0] b;
   } row_t;

   logic        vga_clk = 1'b0;
   logic        rst;
   logic        frame_start;
   logic        pix_valid;
   logic [15:0] pix_data;
   logic        pix_ready;
   logic        busy;
   logic        frame_done;
   logic        ram_we;
   logic [5:0]  ram_addr;
   logic [63:0] red_ram_data;
   logic [63:0] green_ram_data;
   logic [63:0] blue_ram_data;

   row_t exp_q[$];
   row_t mon_e;
   int   n_vec  = 0;
   int   n_err  = 0;
   int   n_done = 0;
   int   row;
   logic mon_last_wr = 1'b0;

   always #5 vga_clk = ~vga_clk;

   vga_bitplane_writer dut (
      .vga_clk        (vga_clk),
      .rst            (rst),
      .frame_start    (frame_start),
      .pix_valid      (pix_valid),
      .pix_data       (pix_data),
      .pix_ready      (pix_ready),
      .busy           (busy),
      .frame_done     (frame_done),
      .ram_we         (ram_we),
      .ram_addr       (ram_addr),
      .red_ram_data   (red_ram_data),
      .green_ram_data (green_ram_data),
      .blue_ram_data  (blue_ram_data)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: score every row write and the frame_done pulse position
   always @(negedge vga_clk) begin
      if (rst) begin
         mon_last_wr = 1'b0;
      end else begin
         if (ram_we) begin
            chk("pix_ready_in_write", 64'(pix_ready), 64'd0);
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_write: got addr %0d expected no write", ram_addr);
            end else begin
               mon_e = exp_q.pop_front();
               chk("ram_addr", 64'(ram_addr), 64'(mon_e.addr));
               chk("red_row", red_ram_data, mon_e.r);
               chk("green_row", green_ram_data, mon_e.g);
               chk("blue_row", blue_ram_data, mon_e.b);
            end
         end
         if (frame_done || mon_last_wr)
            chk("frame_done_timing", 64'(frame_done), 64'(mon_last_wr));
         if (frame_done) n_done++;
         mon_last_wr = ram_we && (ram_addr == 6'd63);
      end
   end

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic exp_row(input int a, input logic [63:0] r, input logic [63:0] g, input logic [63:0] b);
      exp_q.push_back('{addr: 6'(a), r: r, g: g, b: b});
   endtask

   task automatic send_px(input logic [15:0] d, input bit gaps);
      int n;
      while (gaps && ($urandom_range(1, 0) == 1)) begin
         pix_valid = 1'b0;
         tick();
      end
      pix_valid = 1'b1;
      pix_data  = d;
      n = 0;
      while (!pix_ready && n < C_TIMEOUT) begin
         tick();
         n++;
      end
      if (!pix_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL pix_ready_timeout: got 0 expected 1");
      end
      tick();
      pix_valid = 1'b0;
   endtask

   // Pixel 0 uses 'first', later odd x use 'odd', later even x use 'even'
   task automatic send_row(input logic [15:0] first, input logic [15:0] odd,
                           input logic [15:0] even, input bit gaps);
      for (int x = 0; x < 64; x++) begin
         if (x == 0)          send_px(first, gaps);
         else if (x % 2 == 1) send_px(odd, gaps);
         else                 send_px(even, gaps);
      end
   endtask

   task automatic pulse_fs(input bit v, input logic [15:0] d);
      frame_start = 1'b1;
      pix_valid   = v;
      pix_data    = d;
      tick();
      frame_start = 1'b0;
      pix_valid   = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = 16'h0000;
      tick(); tick();
      chk("rst_pix_ready", 64'(pix_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
      chk("rst_ram_we", 64'(ram_we), 64'd0);
      chk("rst_ram_addr", 64'(ram_addr), 64'd0);
      chk("rst_red", red_ram_data, 64'd0);
      chk("rst_green", green_ram_data, 64'd0);
      chk("rst_blue", blue_ram_data, 64'd0);

      // Valid pixels while idle must not be accepted
      rst = 1'b0; pix_valid = 1'b1; pix_data = 16'hFFFF;
      repeat (4) begin
         tick();
         chk("idle_pix_ready", 64'(pix_ready), 64'd0);
         chk("idle_busy", 64'(busy), 64'd0);
      end
      pix_valid = 1'b0;

      // Full white frame
      pulse_fs(1'b0, 16'h0000);
      chk("fill_busy", 64'(busy), 64'd1);
      for (int y = 0; y < 64; y++) begin
         exp_row(y, C_ONES, C_ONES, C_ONES);
         send_row(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
      end
      repeat (3) tick();
      chk("busy_after_frame", 64'(busy), 64'd0);
      chk("frame_done_count", 64'(n_done), 64'd1);

      // Single red pixel at x=0
      pulse_fs(1'b0, 16'h0000);
      exp_row(0, 64'h8000_0000_0000_0000, 64'd0, 64'd0);
      send_row(16'hF800, 16'h0000, 16'h0000, 1'b0);
      row = 1;

`ifndef VGA_BITPLANE_DITHER_EN
      // Threshold boundaries: one below, then exactly at threshold
      exp_row(row, 64'd0, 64'd0, 64'd0);
      send_row(16'h7BEF, 16'h7BEF, 16'h7BEF, 1'b0);
      row++;
      exp_row(row, C_ONES, C_ONES, C_ONES);
      send_row(16'h8410, 16'h8410, 16'h8410, 1'b0);
      row++;
`endif

      // Green on odd pixels with random valid gaps
      repeat (2) begin
         exp_row(row, 64'd0, 64'h5555_5555_5555_5555, 64'd0);
         send_row(16'h0000, 16'h07E0, 16'h0000, 1'b1);
         row++;
      end

      // Abort at row 10 pixel 20; the restart-cycle pixel must be dropped
      pulse_fs(1'b0, 16'h0000);
      for (int y = 0; y < 10; y++) begin
         exp_row(y, 64'd0, 64'd0, 64'd0);
         send_row(16'h0000, 16'h0000, 16'h0000, 1'b0);
      end
      repeat (20) send_px(16'h1234, 1'b0);
      pulse_fs(1'b1, 16'h0000);
      exp_row(0, C_ONES, C_ONES, C_ONES);
      send_row(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);

`ifdef VGA_BITPLANE_DITHER_EN
      pulse_fs(1'b0, 16'h0000);
      exp_row(0, 64'hAAAA_AAAA_AAAA_AAAA, 64'd0, 64'd0);
      send_row(16'h8000, 16'h8000, 16'h8000, 1'b0);
      exp_row(1, 64'h5555_5555_5555_5555, 64'd0, 64'd0);
      send_row(16'h8000, 16'h8000, 16'h8000, 1'b0);
`endif

      // Reset in the middle of a row
      repeat (30) send_px(16'hFFFF, 1'b0);
      rst = 1'b1;
      tick();
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_pix_ready", 64'(pix_ready), 64'd0);
      chk("midrst_ram_addr", 64'(ram_addr), 64'd0);
      chk("midrst_red", red_ram_data, 64'd0);
      rst = 1'b0;
      repeat (5) tick();
      chk("post_rst_busy", 64'(busy), 64'd0);

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      chk("frame_done_total", 64'(n_done), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
